// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, buffers completed fetches in a small
// FIFO and hands {pc, inst} pairs to decode. A branch redirects the PC, clears
// the buffer and inserts one bubble cycle so the in-flight stale fetch is dropped.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        if_stallreq_i,
  input  logic [31:0] if_inst_i,
  output logic [31:0] if_addr_o,
  input  logic        id_stall_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {FETCH, BUBBLE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [31:0]   inst_mem_q [FIFO_DEPTH];

  logic full, fetch_done, push, pop;

  assign full       = (cnt_q == FULL_CNT);
  assign id_valid_o = (cnt_q != '0);
  assign if_addr_o  = pc_q;
  // Head fields are forced to zero when nothing is buffered so ID never sees stale data.
  assign id_pc_o    = id_valid_o ? pc_mem_q[rd_q]   : 32'h0;
  assign id_inst_o  = id_valid_o ? inst_mem_q[rd_q] : 32'h0;

  // Next-state: branch wins over push/pop; a full buffer drops the completion and refetches.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    fetch_done = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (rdy) begin
      if (branch_flag_i) begin
        pc_d    = branch_target_i;
        state_d = BUBBLE;
        rd_d    = '0;
        wr_d    = '0;
        cnt_d   = '0;
      end else begin
        pop        = id_valid_o & ~id_stall_i;
        fetch_done = ~if_stallreq_i & (state_q == FETCH);
        push       = fetch_done & (~full | pop);
        state_d    = FETCH;
        if (push) begin
          wr_d = wr_q + 1'b1;
          pc_d = pc_q + 32'd4;
        end
        if (pop) rd_d = rd_q + 1'b1;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Buffer storage; contents are only meaningful while counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem_q[wr_q]   <= pc_q;
      inst_mem_q[wr_q] <= if_inst_i;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a reference model keeps the expected buffer contents
// in a scoreboard queue; scenario tasks compare DUT outputs against it and
// against hand-derived constants.
module tb_if_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, branch_flag, if_stallreq, id_stall;
  logic [31:0] branch_target, if_inst, if_addr, id_pc, id_inst;
  logic        id_valid;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .branch_flag_i(branch_flag), .branch_target_i(branch_target),
    .if_stallreq_i(if_stallreq), .if_inst_i(if_inst), .if_addr_o(if_addr),
    .id_stall_i(id_stall), .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t        sb[$];
  logic [31:0] m_pc;
  bit          m_bubble;

  // Advance one clock: update the model with the inputs seen at the edge,
  // then return at the falling edge where outputs are sampled and inputs change.
  task automatic tick();
    bit full, pop, done;
    @(posedge clk);
    if (rst) begin
      sb.delete(); m_pc = RPC; m_bubble = 0;
    end else if (rdy) begin
      if (branch_flag) begin
        sb.delete(); m_pc = branch_target; m_bubble = 1;
      end else begin
        full = (sb.size() == DEPTH);
        pop  = (sb.size() != 0) && !id_stall;
        done = !if_stallreq && !m_bubble;
        if (pop) void'(sb.pop_front());
        if (done && (!full || pop)) begin
          sb.push_back('{pc: m_pc, inst: if_inst});
          m_pc = m_pc + 32'd4;
        end
        m_bubble = 0;
      end
    end
    @(negedge clk);
    if_inst = $urandom();
  endtask

  task automatic do_reset();
    rst = 1; rdy = 1; branch_flag = 0; branch_target = 0;
    if_stallreq = 1; id_stall = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", id_pc); end
    checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", id_inst); end
    checks++; if (if_addr !== RPC) begin errors++; $display("FAIL reset_addr got %h want %h", if_addr, RPC); end
  endtask

  // One fetch completion every 4th cycle, ID always ready: PCs stream out 0,4,8,...
  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    exp = 0;
    for (int i = 0; i < 24; i++) begin
      if_stallreq = (i % 4 != 0); id_stall = 0;
      checks++; if (if_addr !== m_pc) begin errors++; $display("FAIL stream_addr got %h want %h", if_addr, m_pc); end
      checks++; if (id_valid !== (sb.size() != 0)) begin errors++; $display("FAIL stream_valid got %0h want %0d", id_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        checks++;
        if (id_pc !== exp || id_inst !== sb[0].inst) begin
          errors++; $display("FAIL stream_head got %h/%h want %h/%h", id_pc, id_inst, exp, sb[0].inst);
        end
        exp += 4;
      end
      tick();
    end
    checks++; if (exp !== 32'd24) begin errors++; $display("FAIL stream_count got %0d want 24", exp); end
  endtask

  // ID stalled: two completions buffered, third dropped and refetched after drain.
  task automatic test_full_drop();
    do_reset();
    id_stall = 1; if_stallreq = 0;
    repeat (3) tick();
    checks++; if (if_addr !== 32'h8) begin errors++; $display("FAIL drop_addr got %h want 8", if_addr); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL drop_head got %0h/%h want 1/0", id_valid, id_pc); end
    if_stallreq = 1; id_stall = 0;
    tick();
    checks++; if (id_pc !== 32'h4 || id_inst !== sb[0].inst) begin errors++; $display("FAIL drain_second got %h want 4", id_pc); end
    tick();
    checks++; if (id_valid !== 1'b0 || if_addr !== 32'h8) begin errors++; $display("FAIL drain_empty got %0h/%h want 0/8", id_valid, if_addr); end
    if_stallreq = 0;
    tick();
    checks++; if (id_pc !== 32'h8 || if_addr !== 32'hC) begin errors++; $display("FAIL resume got %h/%h want 8/c", id_pc, if_addr); end
  endtask

  // Full buffer with simultaneous completion and pop: occupancy stays at 2.
  task automatic test_push_pop_full();
    id_stall = 1; if_stallreq = 0;
    tick();
    id_stall = 0;
    tick();
    checks++; if (if_addr !== 32'h14 || id_pc !== 32'hC) begin errors++; $display("FAIL pushpop got %h/%h want 14/c", if_addr, id_pc); end
    id_stall = 1;
    tick();
    checks++; if (if_addr !== 32'h14 || id_pc !== 32'hC || sb.size() != 2) begin errors++; $display("FAIL pushpop_full got %h/%h want 14/c", if_addr, id_pc); end
  endtask

  // Redirect with a full buffer, bubble drops a completion, re-redirect inside bubble.
  task automatic test_branch();
    id_stall = 0; if_stallreq = 0; branch_flag = 1; branch_target = 32'h100;
    tick();
    branch_flag = 0;
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0) begin errors++; $display("FAIL br_flush got %0h/%h/%h want 0/0/0", id_valid, id_pc, id_inst); end
    checks++; if (if_addr !== 32'h100) begin errors++; $display("FAIL br_addr got %h want 100", if_addr); end
    tick();
    checks++; if (id_valid !== 1'b0 || if_addr !== 32'h100) begin errors++; $display("FAIL br_bubble got %0h/%h want 0/100", id_valid, if_addr); end
    tick();
    checks++; if (id_pc !== 32'h100 || id_inst !== sb[0].inst || if_addr !== 32'h104) begin errors++; $display("FAIL br_first got %h/%h want 100/104", id_pc, if_addr); end
    branch_flag = 1; branch_target = 32'h200;
    tick();
    branch_target = 32'h300;
    tick();
    branch_flag = 0;
    checks++; if (id_valid !== 1'b0 || if_addr !== 32'h300) begin errors++; $display("FAIL br_rebranch got %0h/%h want 0/300", id_valid, if_addr); end
    tick();
    checks++; if (id_valid !== 1'b0 || if_addr !== 32'h300) begin errors++; $display("FAIL br_rebubble got %0h/%h want 0/300", id_valid, if_addr); end
    tick();
    checks++; if (id_pc !== 32'h300 || if_addr !== 32'h304) begin errors++; $display("FAIL br_second got %h/%h want 300/304", id_pc, if_addr); end
  endtask

  // rdy low freezes everything, including branch and pop.
  task automatic test_rdy_freeze();
    id_stall = 1; if_stallreq = 0;
    tick();
    rdy = 0; id_stall = 0; branch_flag = 1; branch_target = 32'h500;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (if_addr !== 32'h308 || id_valid !== 1'b1 || id_pc !== 32'h300 || id_inst !== sb[0].inst) begin
        errors++; $display("FAIL freeze_%0d got %h/%0h/%h want 308/1/300", i, if_addr, id_valid, id_pc);
      end
    end
    rdy = 1; branch_flag = 0; id_stall = 1; if_stallreq = 1;
    tick();
  endtask

  // Reset with a non-empty buffer, and again while in the bubble state.
  task automatic test_reset_mid();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || if_addr !== RPC) begin errors++; $display("FAIL rst_full got %0h/%h/%h want 0/0/0", id_valid, id_pc, if_addr); end
    if_stallreq = 0; id_stall = 1;
    tick();
    branch_flag = 1; branch_target = 32'h40;
    tick();
    branch_flag = 0; rst = 1;
    tick();
    rst = 0;
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0 || if_addr !== RPC) begin errors++; $display("FAIL rst_bubble got %0h/%h/%h want 0/0/0", id_valid, id_inst, if_addr); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || if_addr !== 32'h4) begin errors++; $display("FAIL rst_refetch got %0h/%h/%h want 1/0/4", id_valid, id_pc, if_addr); end
  endtask

  initial begin
    rst = 1; rdy = 1; branch_flag = 0; branch_target = 0;
    if_stallreq = 1; id_stall = 0; if_inst = 32'h1234_5678;
    m_pc = RPC; m_bubble = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_full_drop();
    test_push_pop_full();
    test_branch();
    test_rdy_freeze();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
